// File: rtl/cac_dec_arbiter_if.sv
// Request/response bundle between requester lanes and the CAC decoder arbiter.
//
// Handshake rules (both channels):
//   - A transfer happens on a rising clk edge where valid and ready are both 1.
//   - Requests: req_valid[i] is raised by lane i; the arbiter raises at most
//     one req_ready bit, combinationally, in the same cycle. A lane may drop
//     req_valid at any time while not granted; it simply loses its turn.
//   - Responses: once rsp_valid is 1, rsp_lane and rsp_data stay stable until
//     the cycle in which rsp_ready is also 1.
//
// Signals:
//   req_valid [N_LANE]    per-lane request valid        (master -> slave)
//   req_code  [5*N_LANE]  per-lane codeword, lane i at [5i+4:5i]
//   req_ready [N_LANE]    per-lane accept, one-hot or 0 (slave -> master)
//   rsp_valid             response valid                (slave -> master)
//   rsp_ready             response consumer ready       (master -> slave)
//   rsp_lane  [LW]        lane tag of the response
//   rsp_data  [BW]        decoded value
interface cac_dec_arbiter_if #(
  parameter int N_LANE = 4,
  parameter int LW     = 2,
  parameter int BW     = 4
);
  logic [N_LANE-1:0]   req_valid;
  logic [5*N_LANE-1:0] req_code;
  logic [N_LANE-1:0]   req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [LW-1:0]       rsp_lane;
  logic [BW-1:0]       rsp_data;

  modport master (
    output req_valid, req_code, rsp_ready,
    input  req_ready, rsp_valid, rsp_lane, rsp_data
  );

  modport slave (
    input  req_valid, req_code, rsp_ready,
    output req_ready, rsp_valid, rsp_lane, rsp_data
  );
endinterface

// File: rtl/cac_dec_arbiter.sv
// Round-robin scheduler sharing one external 5-bit CAC decoder among N_LANE
// requester lanes. Each lane owns a configurable Fibonacci weight set
// (fns03/fns04/fns05). A grant snapshots the codeword and the lane's weights
// onto the dec_* ports, the decoder result is captured one cycle later and is
// returned with the lane tag on the response channel.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   bus (slave)           request/response channels, see cac_dec_arbiter_if
//   cfg_we, cfg_lane      weight-table write strobe and target lane
//   cfg_fns03/04/05       weights for codeword bits 2/3/4
//   dec_codein            codeword to the external decoder
//   dec_fns03/04/05       weight snapshot to the external decoder
//   dec_dataout           decoder result (combinational from dec_* outputs)
//   dec_count             completed responses, saturating
//   dbg_state             current FSM state (IDLE=0, DEC=1, RESP=2)
module cac_dec_arbiter #(
  parameter int N_LANE = 4,
  parameter int LW     = 2,
  parameter int FW     = 3,
  parameter int BW     = 4,
  parameter int CW     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  cac_dec_arbiter_if.slave    bus,
  input  logic                cfg_we,
  input  logic [LW-1:0]       cfg_lane,
  input  logic [FW-1:0]       cfg_fns03,
  input  logic [FW-1:0]       cfg_fns04,
  input  logic [FW-1:0]       cfg_fns05,
  output logic [4:0]          dec_codein,
  output logic [FW-1:0]       dec_fns03,
  output logic [FW-1:0]       dec_fns04,
  output logic [FW-1:0]       dec_fns05,
  input  logic [BW-1:0]       dec_dataout,
  output logic [CW-1:0]       dec_count,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEC  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;

  logic [LW-1:0] ptr;       // lane with highest priority at the next search
  logic [LW-1:0] gnt_lane;  // lane currently in flight
  logic [LW-1:0] gnt;       // search result this cycle
  logic          found;
  int            idx;

  logic [FW-1:0] wt03 [N_LANE];
  logic [FW-1:0] wt04 [N_LANE];
  logic [FW-1:0] wt05 [N_LANE];

  assign dbg_state = state;

  // Round-robin search: first valid lane at or above ptr, wrapping at N_LANE.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int i = 0; i < N_LANE; i++) begin
      idx = (int'(ptr) + i) % N_LANE;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        gnt   = LW'(idx);
      end
    end
  end

  // Next state and the combinational grant.
  always_comb begin
    state_nx      = state;
    bus.req_ready = '0;
    case (state)
      IDLE: begin
        if (found) begin
          bus.req_ready[gnt] = 1'b1;
          state_nx           = DEC;
        end
      end
      DEC:     state_nx = RESP;
      RESP:    if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Weight table. Writes land in any state; the in-flight request is
  // unaffected because it works from the dec_fns* snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_LANE; i++) begin
        wt03[i] <= FW'(2);
        wt04[i] <= FW'(3);
        wt05[i] <= FW'(5);
      end
    end else if (cfg_we && (int'(cfg_lane) < N_LANE)) begin
      wt03[cfg_lane] <= cfg_fns03;
      wt04[cfg_lane] <= cfg_fns04;
      wt05[cfg_lane] <= cfg_fns05;
    end
  end

  // Datapath: grant snapshot, result capture, response retirement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_lane      <= '0;
      ptr           <= '0;
      dec_codein    <= '0;
      dec_fns03     <= '0;
      dec_fns04     <= '0;
      dec_fns05     <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_lane  <= '0;
      bus.rsp_data  <= '0;
      dec_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt_lane   <= gnt;
            dec_codein <= bus.req_code[5*int'(gnt) +: 5];
            dec_fns03  <= wt03[gnt];
            dec_fns04  <= wt04[gnt];
            dec_fns05  <= wt05[gnt];
          end
        end
        DEC: begin
          bus.rsp_data  <= dec_dataout;
          bus.rsp_lane  <= gnt_lane;
          bus.rsp_valid <= 1'b1;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            ptr <= (gnt_lane == LW'(N_LANE - 1)) ? '0 : gnt_lane + LW'(1);
            if (dec_count != '1) dec_count <= dec_count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cac_dec_arbiter.sv
module tb_cac_dec_arbiter;
  localparam int N_LANE = 4;
  localparam int LW     = 2;
  localparam int FW     = 3;
  localparam int BW     = 4;
  localparam int CW     = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(negedge clk) cyc++;

  // ---------------- DUT and decoder model ----------------
  cac_dec_arbiter_if #(.N_LANE(N_LANE), .LW(LW), .BW(BW)) bus ();

  logic          cfg_we = 1'b0;
  logic [LW-1:0] cfg_lane = '0;
  logic [FW-1:0] cfg_fns03 = '0, cfg_fns04 = '0, cfg_fns05 = '0;
  logic [4:0]    dec_codein;
  logic [FW-1:0] dec_fns03, dec_fns04, dec_fns05;
  logic [BW-1:0] dec_dataout;
  logic [CW-1:0] dec_count;
  logic [1:0]    dbg_state;

  cac_dec_arbiter #(.N_LANE(N_LANE), .LW(LW), .FW(FW), .BW(BW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .cfg_we(cfg_we), .cfg_lane(cfg_lane),
    .cfg_fns03(cfg_fns03), .cfg_fns04(cfg_fns04), .cfg_fns05(cfg_fns05),
    .dec_codein(dec_codein), .dec_fns03(dec_fns03), .dec_fns04(dec_fns04),
    .dec_fns05(dec_fns05), .dec_dataout(dec_dataout),
    .dec_count(dec_count), .dbg_state(dbg_state)
  );

  // External decoder: bits 0,1 weigh 1 each, bits 2..4 use the snapshot.
  logic [7:0] dec_sum;
  always_comb begin
    dec_sum = 8'(dec_codein[0]) + 8'(dec_codein[1])
            + (dec_codein[2] ? 8'(dec_fns03) : 8'd0)
            + (dec_codein[3] ? 8'(dec_fns04) : 8'd0)
            + (dec_codein[4] ? 8'(dec_fns05) : 8'd0);
    dec_dataout = dec_sum[BW-1:0];
  end

  // ---------------- scoreboard ----------------
  logic [LW+BW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Monitor: every accepted response is matched against the queue head.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected_lane", 32'(bus.rsp_lane), 32'hFFFF);
      end else begin
        logic [LW+BW-1:0] e;
        e = exp_q.pop_front();
        chk("rsp_lane", 32'(bus.rsp_lane), 32'(e[LW+BW-1:BW]));
        chk("rsp_data", 32'(bus.rsp_data), 32'(e[BW-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_code  = '0;
    bus.rsp_ready = 1'b0;
    cfg_we = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_grant(output logic [N_LANE-1:0] rr);
    int n;
    n  = 0;
    rr = '0;
    do begin
      @(negedge clk);
      rr = bus.req_ready;
      n++;
    end while (rr == '0 && n < 20);
    if (rr == '0) fail_now("grant_wait");
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || bus.rsp_valid) && n < 40);
    if (exp_q.size() != 0 || bus.rsp_valid) fail_now("drain");
  endtask

  task automatic push_exp(input int lane, input logic [BW-1:0] data);
    logic [LW-1:0] l;
    l = LW'(lane);
    exp_q.push_back({l, data});
  endtask

  task automatic send(input int lane, input logic [4:0] code, input logic [BW-1:0] exp);
    logic [N_LANE-1:0] rr;
    @(posedge clk); #1;
    bus.req_valid[lane] = 1'b1;
    bus.req_code[5*lane +: 5] = code;
    wait_grant(rr);
    chk("send_grant", 32'(rr), 32'(1) << lane);
    if (rr != '0) push_exp(lane, exp);
    @(posedge clk); #1;
    bus.req_valid[lane] = 1'b0;
    drain();
  endtask

  task automatic cfg(input int lane, input logic [FW-1:0] a, input logic [FW-1:0] b,
                     input logic [FW-1:0] c);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_lane = LW'(lane);
    cfg_fns03 = a; cfg_fns04 = b; cfg_fns05 = c;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [N_LANE-1:0] rr;
  int last_g;
  logic [4:0]    codes [8] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000,
                               5'b10000, 5'b11111, 5'b01010, 5'b10101};
  logic [BW-1:0] datas [8] = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd5, 4'd12, 4'd4, 4'd8};

  initial begin
    // Test 1: reset values, single request timing
    do_reset();
    @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_lane",  32'(bus.rsp_lane), 0);
    chk("rst_rsp_data",  32'(bus.rsp_data), 0);
    chk("rst_dec_codein", 32'(dec_codein), 0);
    chk("rst_dec_fns", 32'({dec_fns03, dec_fns04, dec_fns05}), 0);
    chk("rst_dec_count", 32'(dec_count), 0);
    chk("rst_state", 32'(dbg_state), 0);

    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b1;
    bus.req_code[4:0] = 5'b10101;
    @(negedge clk);
    chk("t1_ready_cycle0", 32'(bus.req_ready), 32'b0001);
    push_exp(0, 4'd8);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t1_no_rsp_cycle1", 32'(bus.rsp_valid), 0);
    chk("t1_dec_codein", 32'(dec_codein), 32'b10101);
    chk("t1_dec_fns", 32'({dec_fns03, dec_fns04, dec_fns05}), 32'({3'd2, 3'd3, 3'd5}));
    chk("t1_ready_in_dec", 32'(bus.req_ready), 0);
    @(negedge clk);
    chk("t1_rsp_cycle2", 32'(bus.rsp_valid), 1);
    @(negedge clk);
    chk("t1_dec_count", 32'(dec_count), 1);
    chk("t1_codein_held", 32'(dec_codein), 32'b10101);

    // Test 2: all lanes valid, round robin, 3-cycle spacing
    do_reset();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_code  = {4{5'b11111}};
    bus.req_valid = 4'b1111;
    last_g = 0;
    for (int k = 0; k < 8; k++) begin
      wait_grant(rr);
      chk("t2_grant_order", 32'(rr), 32'(1) << (k % 4));
      if (k > 0) chk("t2_spacing", 32'(cyc - last_g), 3);
      last_g = cyc;
      push_exp(k % 4, 4'd12);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    drain();
    chk("t2_dec_count", 32'(dec_count), 8);

    // Test 3: per-lane weights
    cfg(2, 3'd3, 3'd4, 3'd7);
    send(2, 5'b11100, 4'd14);
    send(1, 5'b11100, 4'd10);

    // Test 4: snapshot survives a cfg write during DEC; response held
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid[3] = 1'b1;
    bus.req_code[19:15] = 5'b10000;
    wait_grant(rr);
    chk("t4_grant", 32'(rr), 32'b1000);
    push_exp(3, 4'd5);
    @(posedge clk); #1;
    bus.req_valid[3] = 1'b0;
    cfg_we = 1'b1; cfg_lane = 2'd3;
    cfg_fns03 = 3'd2; cfg_fns04 = 3'd3; cfg_fns05 = 3'd1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(bus.rsp_valid), 1);
      chk("t4_hold_data", 32'(bus.rsp_data), 5);
      chk("t4_hold_lane", 32'(bus.rsp_lane), 3);
      if (k == 0) chk("t4_snapshot_fns05", 32'(dec_fns05), 5);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    drain();
    send(3, 5'b10000, 4'd1);

    // Test 5: reset during RESP drops the in-flight request
    send(2, 5'b00100, 4'd3);  // leaves the pointer at lane 3
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b1;
    bus.req_code[9:5] = 5'b11111;
    wait_grant(rr);
    chk("t5_grant", 32'(rr), 32'b0010);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_in_resp", 32'(bus.rsp_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("t5_rst_state", 32'(dbg_state), 0);
    chk("t5_rst_codein", 32'(dec_codein), 0);
    chk("t5_rst_count", 32'(dec_count), 0);
    chk("t5_rst_rsp_data", 32'(bus.rsp_data), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_code[4:0]   = 5'b00001;
    bus.req_code[19:15] = 5'b10000;
    bus.req_valid = 4'b1001;
    wait_grant(rr);
    chk("t5_ptr_reset", 32'(rr), 32'b0001);
    push_exp(0, 4'd1);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    wait_grant(rr);
    chk("t5_next_grant", 32'(rr), 32'b1000);
    push_exp(3, 4'd5);  // lane3 weight back to 5
    @(posedge clk); #1;
    bus.req_valid[3] = 1'b0;
    drain();
    send(2, 5'b11100, 4'd10);  // lane2 weights back to {2,3,5}
    chk("t5_count_after", 32'(dec_count), 3);

    // Test 6: saturating count (CW=4)
    for (int k = 0; k < 17; k++) send(k % 4, codes[k % 8], datas[k % 8]);
    chk("t6_count_sat", 32'(dec_count), 15);
    chk("t6_queue_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cac_dec_arbiter.md
Name: cac_dec_arbiter

Overview:
- Round-robin scheduler that time-shares one external 5-bit CAC decoder datapath among N_LANE requester lanes.
- Holds a per-lane Fibonacci weight set (FNS03/FNS04/FNS05) that software can configure.
- For each granted request it drives the codeword and weight snapshot onto the decoder ports, captures the decoded value, and returns it with a lane tag over a valid/ready response channel.

Parameters:
N_LANE, 4, number of requester lanes (2..8)
LW, 2, lane index width, equal to clog2(N_LANE)
FW, 3, width of each FNS weight
BW, 4, decoded data width; also the width of dec_dataout
CW, 16, width of the decode-count statistics counter

Ports:
clk  in  1  single clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_LANE  per-lane request valid
req_code  in  5*N_LANE  per-lane codeword; lane i occupies [5i+4:5i]
req_ready  out  N_LANE  per-lane accept; one-hot or zero
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_lane  out  LW  lane that issued the response
rsp_data  out  BW  decoded value
cfg_we  in  1  weight-table write strobe
cfg_lane  in  LW  lane being configured
cfg_fns03  in  FW  weight for codeword bit 2
cfg_fns04  in  FW  weight for codeword bit 3
cfg_fns05  in  FW  weight for codeword bit 4
dec_codein  out  5  to decoder codeword input
dec_fns03  out  FW  to decoder weight input for bit 2
dec_fns04  out  FW  to decoder weight input for bit 3
dec_fns05  out  FW  to decoder weight input for bit 4
dec_dataout  in  BW  decoder result, combinational from dec_* outputs
dec_count  out  CW  count of completed responses, saturating

Behaviour:
- Reset values (asynchronous, rst_n=0):
  - state=IDLE; req_ready=0; rsp_valid=0; rsp_lane=0; rsp_data=0.
  - dec_codein=0; dec_fns03/04/05=0; dec_count=0; round-robin pointer=0.
  - Every lane's weight table entry = {2,3,5}.
- Weight table:
  - When cfg_we=1, entry cfg_lane is written on the next edge. The write is accepted in every state.
  - cfg_lane >= N_LANE: write ignored.
- FSM states: IDLE, DEC, RESP.
- IDLE:
  - If no req_valid bit is set: stay in IDLE, req_ready=0.
  - Otherwise grant the first lane with valid=1, searching upward from the pointer and wrapping at N_LANE.
  - req_ready[g] is asserted combinationally in the same cycle; that cycle is the handshake.
  - On that edge: latch lane g and req_code[g] into dec_codein; latch the weight entry g into dec_fns03/04/05 (snapshot); go to DEC.
- DEC: exactly one cycle.
  - Capture dec_dataout into rsp_data and the granted lane into rsp_lane.
  - Set rsp_valid=1; go to RESP.
- RESP:
  - Hold rsp_valid, rsp_data and rsp_lane stable until rsp_ready=1.
  - On rsp_valid&rsp_ready: rsp_valid=0, pointer=(g+1) mod N_LANE, dec_count+1 (saturates at all-ones), go to IDLE.
- req_ready is 0 in DEC and RESP. Minimum spacing is 3 cycles per request when rsp_ready is held at 1.
- A cfg write to the granted lane during DEC/RESP does not alter the in-flight weights; the snapshot governs. The new value applies from the next grant.
- dec_* outputs keep their last grant values in IDLE; they change only at a grant.
- The decoder sums weights mod 2^BW. The arbiter performs no range check; overflow is a configuration error.
- A lane that deasserts req_valid while not granted simply loses its turn; there is no request latching.
- Fairness: a lane that stays valid is served within N_LANE grants.
- rst_n asserted mid-operation: in-flight request is dropped with no response; state and outputs return to their reset values immediately.

Test Plan:
1. After reset, lane0 valid, code 5'b10101, rsp_ready=1 -> req_ready[0] on cycle 0; rsp_valid on cycle 2 with rsp_lane=0, rsp_data=8; dec_count=1.
2. All 4 lanes valid continuously, codes 5'b11111, rsp_ready=1 -> grants in order 0,1,2,3,0,...; every rsp_data=12; one response per 3 cycles.
3. cfg_we, lane2, weights {3,4,7}; then lane2 code 5'b11100 -> rsp_data=14; lane1 with the same code still returns 10.
4. Lane3 granted with code 5'b10000; cfg write of lane3 fns05=1 during DEC; rsp_ready held 0 for 5 cycles -> rsp_data=5 held stable for all 5 cycles; the next lane3 request 5'b10000 returns 1.
5. rst_n pulled low during RESP with lane1 pending -> rsp_valid=0 immediately; no response for lane1; weights return to {2,3,5}; pointer=0.
6. dec_count preset near saturation (CW=4 build), 17 completed responses -> dec_count stops at 15.
